// File: rtl/utx_pkg.sv
// Shared definitions for the UART transmit path: parity modes and FSM states.
package utx_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } utx_state_t;

  // Any mode other than even/odd (including the illegal value 3) sends no parity bit.
  function automatic bit has_parity(input int mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/utx_fifo.sv
// Synchronous FIFO with registered full/empty/count; shared by the TX and RX paths.
module utx_fifo
  import utx_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;
  logic [AW:0]       count_next;

  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Count follows pushes minus pops; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + (AW + 1)'(1);
      2'b01:   count_next = count - (AW + 1)'(1);
      default: count_next = count;
    endcase
  end

  // Storage array carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at 2**AW; flags are registered from the next count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == FULL_CNT);
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/utx_ctrl.sv
// UART transmitter: FIFO-buffered bytes serialised as start, data, optional parity, stop(s).
module utx_ctrl
  import utx_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BAUD_DIV  = 868,
  parameter int FIFO_AW   = 4,
  parameter int PAR_MODE  = 1,
  parameter int STOP_BITS = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              tx_en,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              ovf_clr,
  output logic              ovf,
  output logic [FIFO_AW:0]  fifo_cnt,
  output logic              busy,
  output logic              uart_tx
);

  localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam int IDX_W = $clog2(DATA_W);
  localparam bit USE_PAR = has_parity(PAR_MODE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("utx_ctrl: DATA_W must be 5..9");
  end
  if (BAUD_DIV < 2) begin : g_bad_baud
    $error("utx_ctrl: BAUD_DIV must be >= 2");
  end
  if (FIFO_AW < 1) begin : g_bad_aw
    $error("utx_ctrl: FIFO_AW must be >= 1");
  end
  if (PAR_MODE < 0 || PAR_MODE > 3) begin : g_bad_par
    $error("utx_ctrl: PAR_MODE must be 0..3");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("utx_ctrl: STOP_BITS must be 1 or 2");
  end

  utx_state_t        state;
  utx_state_t        state_next;
  logic [CNT_W-1:0]  baud_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic              stop_idx;
  logic [DATA_W-1:0] shreg;
  logic              par_bit;
  logic              tx_q;
  logic              busy_q;
  logic              ovf_q;

  logic              bit_end;
  logic              last_stop;
  logic              head_bit;
  logic              can_start;
  logic              tx_next;
  logic              pop_req;
  logic              shift;
  logic              idx_clr;
  logic              idx_inc;
  logic              stop_clr;
  logic              stop_inc;

  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              push;

  assign push      = tx_valid & ~fifo_full;
  assign tx_ready  = ~fifo_full;
  assign uart_tx   = tx_q;
  assign busy      = busy_q;
  assign ovf       = ovf_q;

  assign bit_end   = (baud_cnt == CNT_LAST);
  assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_idx;
  assign head_bit  = (MSB_FIRST != 0) ? shreg[DATA_W-1] : shreg[0];
  assign can_start = tx_en & ~fifo_empty;

  utx_fifo #(
    .DATA_W (DATA_W),
    .AW     (FIFO_AW)
  ) u_fifo (
    .clk       (clk_sys),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (tx_data),
    .pop       (pop_req),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  // Next state plus the line level for the next cycle, so uart_tx comes straight from a flop.
  always_comb begin
    state_next = state;
    tx_next    = tx_q;
    pop_req    = 1'b0;
    shift      = 1'b0;
    idx_clr    = 1'b0;
    idx_inc    = 1'b0;
    stop_clr   = 1'b0;
    stop_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        tx_next = 1'b1;
        if (can_start) begin
          pop_req    = 1'b1;
          state_next = ST_START;
          tx_next    = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_next = ST_DATA;
          tx_next    = head_bit;
          shift      = 1'b1;
          idx_clr    = 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx == IDX_LAST) begin
            if (USE_PAR) begin
              state_next = ST_PARITY;
              tx_next    = par_bit;
            end else begin
              state_next = ST_STOP;
              tx_next    = 1'b1;
              stop_clr   = 1'b1;
            end
          end else begin
            tx_next = head_bit;
            shift   = 1'b1;
            idx_inc = 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_next = ST_STOP;
          tx_next    = 1'b1;
          stop_clr   = 1'b1;
        end
      end
      ST_STOP: begin
        tx_next = 1'b1;
        if (bit_end) begin
          if (last_stop) begin
            if (can_start) begin
              pop_req    = 1'b1;
              state_next = ST_START;
              tx_next    = 1'b0;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            stop_inc = 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  // State, serial line and busy flag; reset drives the line high immediately.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      state  <= state_next;
      tx_q   <= tx_next;
      busy_q <= (state_next != ST_IDLE);
    end
  end

  // Bit-period counter; every state change lands on bit_end, so START always begins at 0.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
    end else if (state == ST_IDLE || bit_end) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + CNT_W'(1);
    end
  end

  // Data-bit and stop-bit indices within the frame.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else begin
      if (idx_clr)      bit_idx <= '0;
      else if (idx_inc) bit_idx <= bit_idx + IDX_W'(1);
      if (stop_clr)      stop_idx <= 1'b0;
      else if (stop_inc) stop_idx <= 1'b1;
    end
  end

  // Shift register and parity are captured at the moment the word leaves the FIFO.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      par_bit <= 1'b0;
    end else if (pop_req) begin
      shreg   <= fifo_rd_data;
      par_bit <= (PAR_MODE == PAR_ODD) ? ~^fifo_rd_data : ^fifo_rd_data;
    end else if (shift) begin
      shreg <= (MSB_FIRST != 0) ? {shreg[DATA_W-2:0], 1'b0} : {1'b0, shreg[DATA_W-1:1]};
    end
  end

  // Sticky overflow; a new overflow in the same cycle as a clear keeps it set.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (tx_valid & fifo_full) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_utx_ctrl.sv
// Testbench for utx_ctrl: three parameterisations checked against a frame-level line model.
module tb_utx_ctrl;

  localparam int BAUD = 4;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;

  logic       tx_en    [3];
  logic       tx_valid [3];
  logic       ovf_clr  [3];
  logic [7:0] tx_data  [3];

  logic       tx_ready_a, ovf_a, busy_a, uart_tx_a;
  logic       tx_ready_b, ovf_b, busy_b, uart_tx_b;
  logic       tx_ready_c, ovf_c, busy_c, uart_tx_c;
  logic [4:0] fifo_cnt_a, fifo_cnt_b;
  logic [2:0] fifo_cnt_c;

  int n_cmp = 0;
  int n_err = 0;

  bit exp_q [$];
  bit cap_q [$];
  int cap_cnt [$];
  int cap_busy;

  always #5 clk_sys = ~clk_sys;

  utx_ctrl #(.DATA_W(8), .BAUD_DIV(BAUD), .FIFO_AW(4), .PAR_MODE(1), .STOP_BITS(1), .MSB_FIRST(1)) dut_a (
    .clk_sys(clk_sys), .rst_n(rst_n), .tx_en(tx_en[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready_a), .ovf_clr(ovf_clr[0]), .ovf(ovf_a), .fifo_cnt(fifo_cnt_a), .busy(busy_a),
    .uart_tx(uart_tx_a));

  utx_ctrl #(.DATA_W(8), .BAUD_DIV(BAUD), .FIFO_AW(4), .PAR_MODE(2), .STOP_BITS(2), .MSB_FIRST(0)) dut_b (
    .clk_sys(clk_sys), .rst_n(rst_n), .tx_en(tx_en[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready_b), .ovf_clr(ovf_clr[1]), .ovf(ovf_b), .fifo_cnt(fifo_cnt_b), .busy(busy_b),
    .uart_tx(uart_tx_b));

  utx_ctrl #(.DATA_W(8), .BAUD_DIV(BAUD), .FIFO_AW(2), .PAR_MODE(1), .STOP_BITS(1), .MSB_FIRST(1)) dut_c (
    .clk_sys(clk_sys), .rst_n(rst_n), .tx_en(tx_en[2]), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready_c), .ovf_clr(ovf_clr[2]), .ovf(ovf_c), .fifo_cnt(fifo_cnt_c), .busy(busy_c),
    .uart_tx(uart_tx_c));

  function automatic logic get_tx(input int w);
    case (w)
      0: return uart_tx_a;
      1: return uart_tx_b;
      default: return uart_tx_c;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      0: return busy_a;
      1: return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic int get_cnt(input int w);
    case (w)
      0: return int'(fifo_cnt_a);
      1: return int'(fifo_cnt_b);
      default: return int'(fifo_cnt_c);
    endcase
  endfunction

  // Line model: the bit sequence a frame of d must produce, one entry per bit time.
  task automatic build_frame(input logic [7:0] d, input int par, input bit msb, input int stops);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(msb ? d[7-i] : d[i]);
    if (par == 1) exp_q.push_back(bit'(ones % 2));
    else if (par == 2) exp_q.push_back(bit'(1 - (ones % 2)));
    for (int s = 0; s < stops; s++) exp_q.push_back(1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int w = 0; w < 3; w++) begin
      tx_en[w] = 1'b0; tx_valid[w] = 1'b0; ovf_clr[w] = 1'b0; tx_data[w] = 8'h00;
    end
    repeat (3) @(negedge clk_sys);
    rst_n = 1'b1;
    @(negedge clk_sys);
  endtask

  // Called on a negedge; returns on the first negedge that sees the line low.
  task automatic wait_fall(input int w, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (get_tx(w) === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_sys);
    end
  endtask

  // Starting half a cycle into a start bit: sample each bit mid-period, count busy cycles.
  task automatic capture(input int w, input int nbits);
    cap_q.delete();
    cap_cnt.delete();
    cap_busy = 0;
    for (int i = 0; i < nbits; i++) begin
      for (int j = 0; j < BAUD; j++) begin
        if (j == BAUD / 2) begin
          cap_q.push_back(get_tx(w));
          cap_cnt.push_back(get_cnt(w));
        end
        if (get_busy(w) === 1'b1) cap_busy++;
        @(negedge clk_sys);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int w = 0; w < 3; w++) begin
      tx_en[w] = 1'b0; tx_valid[w] = 1'b0; ovf_clr[w] = 1'b0; tx_data[w] = 8'h00;
    end
    repeat (2) @(negedge clk_sys);
    n_cmp++;
    if ({uart_tx_a, busy_a, tx_ready_a, ovf_a, fifo_cnt_a} !== {4'b1010, 5'd0}) begin
      n_err++;
      $display("[TB] FAIL reset_hold got %b expected %b", {uart_tx_a, busy_a, tx_ready_a, ovf_a, fifo_cnt_a}, {4'b1010, 5'd0});
    end
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_sys);
      n_cmp++;
      if ({uart_tx_a, busy_a, tx_ready_a, ovf_a, fifo_cnt_a} !== {4'b1010, 5'd0}) begin
        n_err++;
        $display("[TB] FAIL idle_cycle%0d got %b expected %b", c, {uart_tx_a, busy_a, tx_ready_a, ovf_a, fifo_cnt_a}, {4'b1010, 5'd0});
      end
    end
    n_cmp++;
    if ({uart_tx_b, busy_b, tx_ready_b, uart_tx_c, busy_c, tx_ready_c, fifo_cnt_c} !== {6'b101101, 3'd0}) begin
      n_err++;
      $display("[TB] FAIL idle_b_c got %b expected %b", {uart_tx_b, busy_b, tx_ready_b, uart_tx_c, busy_c, tx_ready_c, fifo_cnt_c}, {6'b101101, 3'd0});
    end
  endtask

  // One frame: latency of the falling edge, the bit sequence and the busy duration.
  task automatic test_single_frame(input int w, input logic [7:0] d, input int par, input bit msb, input int stops);
    int frame_cycles;
    exp_q.delete();
    build_frame(d, par, msb, stops);
    frame_cycles = exp_q.size() * BAUD;
    do_reset();
    tx_en[w] = 1'b1;
    tx_valid[w] = 1'b1;
    tx_data[w] = d;
    @(negedge clk_sys);
    tx_valid[w] = 1'b0;
    n_cmp++;
    if ({get_tx(w), get_busy(w)} !== 2'b10) begin
      n_err++;
      $display("[TB] FAIL latency_early dut%0d got tx/busy %b expected 10", w, {get_tx(w), get_busy(w)});
    end
    @(negedge clk_sys);
    n_cmp++;
    if ({get_tx(w), get_busy(w)} !== 2'b01) begin
      n_err++;
      $display("[TB] FAIL latency_fall dut%0d got tx/busy %b expected 01", w, {get_tx(w), get_busy(w)});
    end
    capture(w, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (cap_q[i] !== exp_q[i]) begin
        n_err++;
        $display("[TB] FAIL frame_bit dut%0d data %h bit %0d got %b expected %b", w, d, i, cap_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (cap_busy != frame_cycles) begin
      n_err++;
      $display("[TB] FAIL busy_len dut%0d got %0d expected %0d", w, cap_busy, frame_cycles);
    end
    n_cmp++;
    if ({get_tx(w), get_busy(w)} !== 2'b10) begin
      n_err++;
      $display("[TB] FAIL after_frame dut%0d got tx/busy %b expected 10", w, {get_tx(w), get_busy(w)});
    end
  endtask

  // Words pushed on consecutive cycles: frames must abut and fifo_cnt must track the backlog.
  task automatic send_burst(input logic [7:0] words [$], input string tag);
    bit ok;
    int n;
    n = words.size();
    exp_q.delete();
    foreach (words[i]) build_frame(words[i], 1, 1'b1, 1);
    tx_en[0] = 1'b1;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          tx_valid[0] = 1'b1;
          tx_data[0] = words[i];
          @(negedge clk_sys);
        end
        tx_valid[0] = 1'b0;
      end
      begin
        wait_fall(0, 10, ok);
        capture(0, exp_q.size());
      end
    join
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("[TB] FAIL %s_start got no start bit expected fall within 10 cycles", tag);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (cap_q[i] !== exp_q[i]) begin
        n_err++;
        $display("[TB] FAIL %s_bit %0d got %b expected %b", tag, i, cap_q[i], exp_q[i]);
      end
    end
    for (int k = 0; k < n; k++) begin
      n_cmp++;
      if (cap_cnt[k*11] != n - (k + 1)) begin
        n_err++;
        $display("[TB] FAIL %s_cnt frame %0d got %0d expected %0d", tag, k, cap_cnt[k*11], n - (k + 1));
      end
    end
    n_cmp++;
    if ({uart_tx_a, busy_a, fifo_cnt_a} !== {2'b10, 5'd0}) begin
      n_err++;
      $display("[TB] FAIL %s_end got %b expected %b", tag, {uart_tx_a, busy_a, fifo_cnt_a}, {2'b10, 5'd0});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [$];
    words = '{8'h11, 8'h00, 8'h85, 8'hAA};
    do_reset();
    send_burst(words, "b2b");
  endtask

  task automatic test_random();
    logic [7:0] words [$];
    do_reset();
    for (int r = 0; r < 4; r++) begin
      words.delete();
      for (int i = 0; i < int'($urandom_range(1, 5)); i++) words.push_back(8'($urandom));
      send_burst(words, "rand");
      repeat ($urandom_range(1, 10)) @(negedge clk_sys);
    end
  endtask

  // Small FIFO held with tx_en low: fill, overflow, clear, then drain in order.
  task automatic test_overflow();
    logic [7:0] model [$];
    bit exp_ready;
    bit ok;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tx_valid[2] = 1'b1;
      tx_data[2] = 8'($urandom);
      exp_ready = (model.size() < 4);
      n_cmp++;
      if (tx_ready_c !== exp_ready) begin
        n_err++;
        $display("[TB] FAIL ovf_ready push %0d got %b expected %b", i, tx_ready_c, exp_ready);
      end
      if (exp_ready) model.push_back(tx_data[2]);
      @(negedge clk_sys);
    end
    tx_valid[2] = 1'b0;
    n_cmp++;
    if ({fifo_cnt_c, tx_ready_c, ovf_c, busy_c} !== {3'd4, 3'b010}) begin
      n_err++;
      $display("[TB] FAIL ovf_full got %b expected %b", {fifo_cnt_c, tx_ready_c, ovf_c, busy_c}, {3'd4, 3'b010});
    end
    ovf_clr[2] = 1'b1;
    @(negedge clk_sys);
    ovf_clr[2] = 1'b0;
    n_cmp++;
    if (ovf_c !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL ovf_clear got %b expected 0", ovf_c);
    end
    tx_valid[2] = 1'b1;
    ovf_clr[2] = 1'b1;
    @(negedge clk_sys);
    tx_valid[2] = 1'b0;
    ovf_clr[2] = 1'b0;
    n_cmp++;
    if ({ovf_c, fifo_cnt_c} !== {1'b1, 3'd4}) begin
      n_err++;
      $display("[TB] FAIL ovf_set_wins got %b expected %b", {ovf_c, fifo_cnt_c}, {1'b1, 3'd4});
    end
    exp_q.delete();
    foreach (model[i]) build_frame(model[i], 1, 1'b1, 1);
    tx_en[2] = 1'b1;
    wait_fall(2, 10, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("[TB] FAIL ovf_drain_start got no start bit expected fall within 10 cycles");
    end
    capture(2, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (cap_q[i] !== exp_q[i]) begin
        n_err++;
        $display("[TB] FAIL ovf_drain_bit %0d got %b expected %b", i, cap_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if ({fifo_cnt_c, busy_c, tx_ready_c} !== {3'd0, 2'b01}) begin
      n_err++;
      $display("[TB] FAIL ovf_drained got %b expected %b", {fifo_cnt_c, busy_c, tx_ready_c}, {3'd0, 2'b01});
    end
  endtask

  // tx_en dropped mid-frame: that frame finishes, the queued word waits until re-enabled.
  task automatic test_tx_en_pause();
    logic [7:0] w0, w1;
    bit ok;
    w0 = 8'($urandom);
    w1 = 8'($urandom);
    do_reset();
    tx_en[0] = 1'b1;
    fork
      begin
        tx_valid[0] = 1'b1; tx_data[0] = w0; @(negedge clk_sys);
        tx_data[0] = w1; @(negedge clk_sys);
        tx_valid[0] = 1'b0;
      end
      begin
        wait_fall(0, 10, ok);
        fork
          capture(0, 11);
          begin repeat (8) @(negedge clk_sys); tx_en[0] = 1'b0; end
        join
      end
    join
    exp_q.delete();
    build_frame(w0, 1, 1'b1, 1);
    for (int i = 0; i < 11; i++) begin
      n_cmp++;
      if (cap_q[i] !== exp_q[i]) begin
        n_err++;
        $display("[TB] FAIL pause_bit %0d got %b expected %b", i, cap_q[i], exp_q[i]);
      end
    end
    for (int c = 0; c < 20; c++) begin
      n_cmp++;
      if ({uart_tx_a, busy_a, fifo_cnt_a} !== {2'b10, 5'd1}) begin
        n_err++;
        $display("[TB] FAIL pause_hold cycle %0d got %b expected %b", c, {uart_tx_a, busy_a, fifo_cnt_a}, {2'b10, 5'd1});
      end
      @(negedge clk_sys);
    end
    tx_en[0] = 1'b1;
    wait_fall(0, 4, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("[TB] FAIL pause_resume got no start bit expected fall within 4 cycles");
    end
    capture(0, 11);
    exp_q.delete();
    build_frame(w1, 1, 1'b1, 1);
    for (int i = 0; i < 11; i++) begin
      n_cmp++;
      if (cap_q[i] !== exp_q[i]) begin
        n_err++;
        $display("[TB] FAIL resume_bit %0d got %b expected %b", i, cap_q[i], exp_q[i]);
      end
    end
  endtask

  // Reset asserted in the data bits of frame 2 of 3: line high at once, nothing further sent.
  task automatic test_reset_mid_frame();
    logic [7:0] words [3];
    bit ok;
    words[0] = 8'($urandom);
    words[1] = 8'($urandom) & 8'h7F;
    words[2] = 8'($urandom);
    do_reset();
    tx_en[0] = 1'b1;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          tx_valid[0] = 1'b1; tx_data[0] = words[i]; @(negedge clk_sys);
        end
        tx_valid[0] = 1'b0;
      end
      begin
        wait_fall(0, 10, ok);
        capture(0, 11);
      end
    join
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("[TB] FAIL rst_mid_start got no start bit expected fall within 10 cycles");
    end
    repeat (6) @(negedge clk_sys);
    n_cmp++;
    if ({uart_tx_a, busy_a} !== 2'b01) begin
      n_err++;
      $display("[TB] FAIL rst_mid_data got tx/busy %b expected 01", {uart_tx_a, busy_a});
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({uart_tx_a, busy_a, tx_ready_a, fifo_cnt_a} !== {3'b101, 5'd0}) begin
      n_err++;
      $display("[TB] FAIL rst_mid_async got %b expected %b", {uart_tx_a, busy_a, tx_ready_a, fifo_cnt_a}, {3'b101, 5'd0});
    end
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_sys);
      n_cmp++;
      if ({uart_tx_a, busy_a, fifo_cnt_a} !== {2'b10, 5'd0}) begin
        n_err++;
        $display("[TB] FAIL rst_mid_after cycle %0d got %b expected %b", c, {uart_tx_a, busy_a, fifo_cnt_a}, {2'b10, 5'd0});
      end
    end
  endtask

  // Hard stop if anything above stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence.
  initial begin
    test_reset();
    test_single_frame(0, 8'h85, 1, 1'b1, 1);
    test_single_frame(1, 8'hAA, 2, 1'b0, 2);
    test_back_to_back();
    test_overflow();
    test_tx_en_pause();
    test_random();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
